instr_fetch: RTL and testbench

Instruction fetch stage of the RISC-V core. It owns the PC and issues word fetches to instruction memory over a req/ready handshake. It holds the returned word in an instruction register, which feeds decode and the immediate generator (instr[31:7]). Redirects from the branch/jump unit (PC + B/J immediate) flush wrong-path work.

---
 rtl/instr_fetch.sv | 124 ++++++++++++
 tb/tb_instr_fetch.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, fetches one word at a time over a req/ready
// handshake, and holds the result in the instruction register until decode takes it.
// Redirects from the branch/jump unit flush wrong-path work. A misaligned redirect
// target parks the stage in an error state (after any in-flight request drains)
// until the next reset.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    localparam logic [2:0] StRstWait = 3'd0;
    localparam logic [2:0] StFetch   = 3'd1;
    localparam logic [2:0] StFlush   = 3'd2;
    localparam logic [2:0] StValid   = 3'd3;
    localparam logic [2:0] StErr     = 3'd4;

    localparam logic [31:0] Nop = 32'h0000_0013;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_err_q, pend_err_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] instr_pc_q, instr_pc_d;
    logic        redir_mis;

    assign redir_mis = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // Next-state logic: PC sequencing, redirect capture and instruction register load.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_pc_d  = pend_pc_q;
        pend_err_d = pend_err_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        case (state_q)
            StRstWait: state_d = StFetch;
            StFetch: begin
                if (imem_ready) begin
                    if (redirect_valid) begin
                        // Returned word is wrong-path; refetch from the target.
                        pc_d    = redirect_pc;
                        state_d = redir_mis ? StErr : StFetch;
                    end else begin
                        instr_d    = imem_rdata;
                        instr_pc_d = pc_q;
                        pc_d       = pc_q + 32'd4;
                        state_d    = StValid;
                    end
                end else if (redirect_valid) begin
                    // Request cannot be withdrawn; remember the target and drain.
                    pend_pc_d  = redirect_pc;
                    pend_err_d = redir_mis;
                    state_d    = StFlush;
                end
            end
            StFlush: begin
                if (redirect_valid) begin
                    pend_pc_d  = redirect_pc;
                    pend_err_d = pend_err_q | redir_mis;
                end
                if (imem_ready) begin
                    pc_d    = redirect_valid ? redirect_pc : pend_pc_q;
                    state_d = (pend_err_q || redir_mis) ? StErr : StFetch;
                end
            end
            StValid: begin
                if (redirect_valid) begin
                    pc_d    = redirect_pc;
                    state_d = redir_mis ? StErr : StFetch;
                end else if (instr_ready) begin
                    state_d = StFetch;
                end
            end
            StErr:   state_d = StErr;
            default: state_d = StRstWait;
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRstWait;
            pc_q       <= RESET_PC;
            pend_pc_q  <= 32'h0;
            pend_err_q <= 1'b0;
            instr_q    <= Nop;
            instr_pc_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_pc_q  <= pend_pc_d;
            pend_err_q <= pend_err_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Outputs decoded from state and registers only; in FLUSH pc_q still holds the
    // address of the in-flight request, so imem_addr stays stable.
    always_comb begin
        imem_req    = (state_q == StFetch) || (state_q == StFlush);
        imem_addr   = pc_q;
        instr_valid = (state_q == StValid);
        fetch_err   = (state_q == StErr);
        instr       = instr_q;
        instr_pc    = instr_pc_q;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus a randomized phase. The reference
// model is architectural: the next instruction delivered to decode must be the word
// at the last redirect target, or at the previous delivered PC + 4.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        rst_n, imem_req, imem_ready, instr_valid, instr_ready;
    logic        redirect_valid, fetch_err;
    logic [31:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;

    logic        rst_w_n, w_req, w_valid, w_err;
    logic [31:0] w_addr, w_instr, w_pc;

    always #5 clk = ~clk;

    instr_fetch #(.RESET_PC(32'h0000_0000)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_err      (fetch_err)
    );

    // Second instance exercising PC wrap-around from the top of the address space.
    instr_fetch #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
        .clk            (clk),
        .rst_n          (rst_w_n),
        .imem_req       (w_req),
        .imem_addr      (w_addr),
        .imem_ready     (1'b1),
        .imem_rdata     (32'h0000_0013),
        .instr_valid    (w_valid),
        .instr_ready    (1'b1),
        .instr          (w_instr),
        .instr_pc       (w_pc),
        .redirect_valid (1'b0),
        .redirect_pc    (32'h0),
        .fetch_err      (w_err)
    );

    int          n_cmp = 0;
    int          n_err = 0;
    int          delivered = 0;
    int          mem_waits = 0;
    bit          err_exp = 1'b0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        if (a == 32'h0)      w = 32'h0050_0093;
        else if (a == 32'h4) w = 32'h00A0_0113;
        else                 w = (a * 32'h9E37_79B1) ^ 32'h0000_0013;
        return w;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    // Drive a redirect for the current cycle and update the architectural model.
    task automatic redirect(input logic [31:0] t);
        redirect_valid = 1'b1;
        redirect_pc    = t;
        exp_q.delete();
        if (t[1:0] != 2'b00) err_exp = 1'b1;
        else exp_q.push_back(t);
    endtask

    // Instruction memory: configurable wait states (negative = random 0..3).
    initial begin : mem_proc
        bit hs, busy;
        int cnt;
        imem_ready = 1'b0;
        imem_rdata = 32'h0;
        busy = 1'b0;
        cnt  = 0;
        forever begin
            @(negedge clk);
            hs = imem_req && imem_ready;
            @(posedge clk);
            #1;
            if (rst_n !== 1'b1) begin
                busy = 1'b0;
                imem_ready = 1'b0;
            end else begin
                if (hs) busy = 1'b0;
                if (imem_req && !busy) begin
                    busy = 1'b1;
                    cnt  = (mem_waits < 0) ? int'($urandom_range(0, 3)) : mem_waits;
                end
                if (busy && cnt == 0) imem_ready = 1'b1;
                else begin
                    imem_ready = 1'b0;
                    if (busy) cnt--;
                end
                imem_rdata = mem_word(imem_addr);
            end
        end
    end

    // Monitor: protocol checks and scoreboard pop on every delivered instruction.
    initial begin : monitor
        bit          pend;
        logic [31:0] paddr, e;
        pend  = 1'b0;
        paddr = 32'h0;
        forever begin
            smp();
            if (rst_n !== 1'b1) pend = 1'b0;
            else begin
                if (pend) begin
                    check("req_held", {31'b0, imem_req}, 32'd1);
                    check("addr_held", imem_addr, paddr);
                end
                if (imem_req) check("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                check("no_spurious_err", {31'b0, fetch_err & ~err_exp}, 32'd0);
                if (instr_valid && instr_ready && !redirect_valid) begin
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL deliver_unexpected: got pc %08h expected no delivery",
                                 instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("deliver_pc", instr_pc, e);
                        check("deliver_instr", instr, mem_word(e));
                        exp_q.push_back(e + 32'd4);
                        delivered++;
                    end
                end
                pend  = imem_req && !imem_ready;
                paddr = imem_addr;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int          reqc, d0;
        bit          drained;
        logic [31:0] held;
        rst_n = 1'b0;
        rst_w_n = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;
        exp_q.push_back(32'h0);
        repeat (3) smp();
        check("rst_req", {31'b0, imem_req}, 32'd0);
        check("rst_addr", imem_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0000_0013);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_err", {31'b0, fetch_err}, 32'd0);

        // Zero-wait fetch of the first two words.
        cyc();
        rst_n = 1'b1;
        instr_ready = 1'b1;
        smp(); check("c1_req", {31'b0, imem_req}, 32'd0);
        smp(); check("c2_req", {31'b0, imem_req}, 32'd1); check("c2_addr", imem_addr, 32'h0);
        smp(); check("c3_valid", {31'b0, instr_valid}, 32'd1);
        check("c3_instr", instr, 32'h0050_0093); check("c3_pc", instr_pc, 32'h0);
        smp(); check("c4_req", {31'b0, imem_req}, 32'd1); check("c4_addr", imem_addr, 32'h4);
        mem_waits = 3;
        smp(); check("c5_instr", instr, 32'h00A0_0113); check("c5_pc", instr_pc, 32'h4);

        // Three wait states, then decode stalls.
        cyc();
        instr_ready = 1'b0;
        reqc = 0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (instr_valid) break;
            if (imem_req && imem_addr == 32'h8) reqc++;
        end
        check("wait_valid_seen", {31'b0, instr_valid}, 32'd1);
        check("wait_req_cycles", reqc, 32'd4);
        check("wait_pc", instr_pc, 32'h8);
        held = instr;
        for (int i = 0; i < 5; i++) begin
            smp();
            check("stall_valid", {31'b0, instr_valid}, 32'd1);
            check("stall_req", {31'b0, imem_req}, 32'd0);
            check("stall_instr", instr, held);
        end
        mem_waits = 0;
        cyc();
        instr_ready = 1'b1;

        // Redirect while valid with decode ready: instruction is squashed.
        cyc();
        instr_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (instr_valid) break;
        end
        cyc();
        instr_ready = 1'b1;
        redirect(32'h100);
        smp();
        cyc();
        redirect_valid = 1'b0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (imem_req) break;
        end
        check("redir_addr", imem_addr, 32'h100);
        for (int k = 0; k < 20; k++) begin
            smp();
            if (instr_valid) break;
        end
        check("redir_pc", instr_pc, 32'h100);
        mem_waits = 4;

        // Two redirects during wait states: address held, youngest target wins.
        cyc();
        smp();
        check("flush_c0_req", {31'b0, imem_req}, 32'd1);
        check("flush_c0_addr", imem_addr, 32'h104);
        cyc(); redirect(32'h200);  smp(); check("flush_c1_addr", imem_addr, 32'h104);
        cyc(); redirect_valid = 1'b0; smp(); check("flush_c2_addr", imem_addr, 32'h104);
        cyc(); redirect(32'h300);  smp(); check("flush_c3_addr", imem_addr, 32'h104);
        cyc(); redirect_valid = 1'b0; smp(); check("flush_c4_addr", imem_addr, 32'h104);
        check("flush_c4_ready", {31'b0, imem_ready}, 32'd1);
        mem_waits = 0;
        cyc(); smp();
        check("flush_new_req", {31'b0, imem_req}, 32'd1);
        check("flush_new_addr", imem_addr, 32'h300);
        for (int k = 0; k < 20; k++) begin
            smp();
            if (instr_valid) break;
        end
        check("flush_pc", instr_pc, 32'h300);
        mem_waits = 3;

        // Misaligned redirect during a wait state: drain, then error until reset.
        cyc();
        redirect(32'h102);
        smp();
        check("mis_req", {31'b0, imem_req}, 32'd1);
        cyc();
        redirect_valid = 1'b0;
        drained = 1'b0;
        for (int k = 0; k < 20; k++) begin
            smp();
            if (fetch_err) break;
            if (imem_req && imem_ready) drained = 1'b1;
        end
        check("mis_err", {31'b0, fetch_err}, 32'd1);
        check("mis_drained", {31'b0, drained}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            smp();
            check("err_req", {31'b0, imem_req}, 32'd0);
            check("err_valid", {31'b0, instr_valid}, 32'd0);
            check("err_sticky", {31'b0, fetch_err}, 32'd1);
        end
        mem_waits = 0;
        cyc();
        rst_n = 1'b0;
        exp_q.delete();
        exp_q.push_back(32'h0);
        err_exp = 1'b0;
        smp();
        check("rerst_err", {31'b0, fetch_err}, 32'd0);
        check("rerst_addr", imem_addr, 32'h0);
        cyc();
        rst_n = 1'b1;
        smp(); smp();
        check("rerst_req", {31'b0, imem_req}, 32'd1);
        check("rerst_fetch_addr", imem_addr, 32'h0);

        // Randomized traffic against the architectural model.
        mem_waits = -1;
        d0 = delivered;
        for (int i = 0; i < 3000; i++) begin
            cyc();
            instr_ready = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) == 0) redirect($urandom_range(0, 1023) * 4);
            else redirect_valid = 1'b0;
        end
        cyc();
        redirect_valid = 1'b0;
        instr_ready = 1'b1;
        repeat (10) cyc();
        check("random_progress", {31'b0, (delivered - d0) >= 200}, 32'd1);

        // PC wrap from 0xFFFF_FFFC to 0x0.
        cyc();
        rst_w_n = 1'b1;
        smp(); check("wrap_c1_req", {31'b0, w_req}, 32'd0);
        smp(); check("wrap_c2_addr", w_addr, 32'hFFFF_FFFC);
        smp(); check("wrap_c3_pc", w_pc, 32'hFFFF_FFFC);
        check("wrap_c3_valid", {31'b0, w_valid}, 32'd1);
        smp(); check("wrap_c4_req", {31'b0, w_req}, 32'd1);
        check("wrap_c4_addr", w_addr, 32'h0);
        check("wrap_err", {31'b0, w_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
